// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: retirement trace FIFO with cycle stamps; halt detection built when PC_TRACE_HALT_DETECT_EN is defined
module pc_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ret_valid_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instr_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [31:0]              rd_cycle_o,
  output logic [31:0]              rd_pc_o,
  output logic [31:0]              rd_instr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     halted_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_cycle [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [31:0]   cyc;
  logic          full, req, push, pop, drop;

  assign rd_valid_o = count_o != '0;
  assign full       = count_o == CW'(DEPTH);
  assign pop        = rd_valid_o && rd_ready_i;
  assign req        = ret_valid_i && !halted_o;
  assign push       = req && (!full || pop);
  assign drop       = req && full && !pop;
  assign rd_cycle_o = mem_cycle[rptr];
  assign rd_pc_o    = mem_pc[rptr];
  assign rd_instr_o = mem_instr[rptr];

  // storage is deliberately left uncleared by reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_cycle[wptr] <= cyc;
      mem_pc[wptr]    <= pc_i;
      mem_instr[wptr] <= instr_i;
    end
  end

  // cycle stamp, pointers, occupancy and drop accounting
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      cyc        <= cyc + 32'd1;
      wptr       <= push ? wptr + 1'b1 : wptr;
      rptr       <= pop ? rptr + 1'b1 : rptr;
      count_o    <= count_o + CW'(push) - CW'(pop);
      overflow_o <= overflow_o || drop;
      drop_cnt_o <= (drop && drop_cnt_o != 16'hFFFF) ? drop_cnt_o + 16'd1 : drop_cnt_o;
    end
  end

`ifdef PC_TRACE_HALT_DETECT_EN
  localparam int RW = $clog2(HALT_REPEAT + 1) + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t        state;
  logic [31:0]   prev_pc;
  logic [RW-1:0] rep;
  logic [RW-1:0] rep_next;

  assign rep_next = (pc_i == prev_pc) ? rep + 1'b1 : RW'(1);

  // halt FSM: a jal-to-self or HALT_REPEAT retirements at one PC freeze capture until reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      halted_o <= 1'b0;
      prev_pc  <= '0;
      rep      <= '0;
    end else if (state == RUN && ret_valid_i) begin
      prev_pc <= pc_i;
      rep     <= rep_next;
      if (instr_i == 32'h0000006F || rep_next >= RW'(HALT_REPEAT)) begin
        state    <= HALTED;
        halted_o <= 1'b1;
      end
    end
  end
`else
  // no halt detection: constant low for any legal HALT_REPEAT
  assign halted_o = HALT_REPEAT < 0;
`endif
endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: directed stimulus with a queue scoreboard drained by a pop monitor
module tb_pc_trace_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ret_valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic        rd_ready_i = 1'b0;
  logic        rd_valid_o;
  logic [31:0] rd_cycle_o, rd_pc_o, rd_instr_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
  logic        halted_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;
  logic [95:0] q[$];

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] JAL = 32'h0000006F;

  pc_trace_buffer #(.DEPTH(16), .HALT_REPEAT(4)) dut (
    .clk(clk), .rst(rst), .ret_valid_i(ret_valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_cycle_o(rd_cycle_o),
    .rd_pc_o(rd_pc_o), .rd_instr_o(rd_instr_o), .count_o(count_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  // monitor: every accepted head entry must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && rd_valid_o && rd_ready_i) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got cycle=%0d pc=%h instr=%h, none expected", rd_cycle_o, rd_pc_o, rd_instr_o);
      end else begin
        logic [95:0] e;
        e = q.pop_front();
        if ({rd_cycle_o, rd_pc_o, rd_instr_o} !== e) begin
          errors++;
          $display("FAIL pop_entry: got cycle=%0d pc=%h instr=%h, want cycle=%0d pc=%h instr=%h",
                   rd_cycle_o, rd_pc_o, rd_instr_o, e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input bit cap);
    ret_valid_i = 1'b1;
    pc_i = pc;
    instr_i = instr;
    if (cap) q.push_back({cyc, pc, instr});
    step();
    ret_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ret_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    step();
    step();
    q.delete();
    rst = 1'b1;
    cyc = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ret_valid_i = 1'b0;
    rd_ready_i = 1'b1;
    while (count_o != 0 && n < 40) begin
      step();
      n++;
    end
    rd_ready_i = 1'b0;
    chk("drain_count", 32'(count_o), 32'd0);
    chk("drain_scoreboard_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    do_reset();
    chk("reset_valid", 32'(rd_valid_o), 32'd0);
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_overflow", 32'(overflow_o), 32'd0);
    chk("reset_drop", 32'(drop_cnt_o), 32'd0);
    chk("reset_halted", 32'(halted_o), 32'd0);

    // three retirements, consumer stalled, then drain in order
    retire(32'h0, NOP, 1);
    retire(32'h4, 32'h00100093, 1);
    retire(32'h8, 32'h00200113, 1);
    chk("t1_count", 32'(count_o), 32'd3);
    chk("t1_head_cycle", rd_cycle_o, 32'd0);
    chk("t1_head_pc", rd_pc_o, 32'h0);
    drain();

    // overfill: 20 pushes into 16 entries
    do_reset();
    for (int i = 0; i < 20; i++) retire(32'h100 + 32'(i) * 4, NOP, i < 16);
    chk("t2_count", 32'(count_o), 32'd16);
    chk("t2_overflow", 32'(overflow_o), 32'd1);
    chk("t2_drop", 32'(drop_cnt_o), 32'd4);
    chk("t2_head_cycle", rd_cycle_o, 32'd0);

    // full FIFO with simultaneous push and pop
    rd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      retire(32'h200 + 32'(i) * 4, 32'h00000033, 1);
      chk("t3_count", 32'(count_o), 32'd16);
      chk("t3_drop", 32'(drop_cnt_o), 32'd4);
    end
    drain();
    chk("t3_overflow_sticky", 32'(overflow_o), 32'd1);

    // reset with entries queued (and halted when detection is built)
    do_reset();
    for (int i = 0; i < 6; i++) retire(32'h300 + 32'(i) * 4, NOP, 1);
    retire(32'h318, JAL, 1);
    chk("t5_pre_count", 32'(count_o), 32'd7);
`ifdef PC_TRACE_HALT_DETECT_EN
    chk("t5_pre_halted", 32'(halted_o), 32'd1);
`endif
    for (int i = 0; i < 12; i++) retire(32'h400, NOP, 0);
    do_reset();
    chk("t5_valid", 32'(rd_valid_o), 32'd0);
    chk("t5_count", 32'(count_o), 32'd0);
    chk("t5_halted", 32'(halted_o), 32'd0);
    chk("t5_overflow", 32'(overflow_o), 32'd0);
    chk("t5_drop", 32'(drop_cnt_o), 32'd0);
    retire(32'h500, NOP, 1);
    chk("t5_first_cycle", rd_cycle_o, 32'd0);
    drain();

`ifdef PC_TRACE_HALT_DETECT_EN
    // jal x0,0 halts on its own retirement and is captured
    do_reset();
    retire(32'h1C, NOP, 1);
    chk("t4a_not_halted", 32'(halted_o), 32'd0);
    retire(32'h20, JAL, 1);
    chk("t4a_halted", 32'(halted_o), 32'd1);
    retire(32'h24, NOP, 0);
    retire(32'h28, NOP, 0);
    chk("t4a_count", 32'(count_o), 32'd2);
    drain();
    chk("t4a_halted_after_drain", 32'(halted_o), 32'd1);

    // fourth retirement at an unchanged PC halts
    do_reset();
    retire(32'h3C, NOP, 1);
    for (int i = 0; i < 3; i++) retire(32'h40, NOP, 1);
    chk("t4b_not_halted", 32'(halted_o), 32'd0);
    retire(32'h40, NOP, 1);
    chk("t4b_halted", 32'(halted_o), 32'd1);
    retire(32'h40, NOP, 0);
    chk("t4b_count", 32'(count_o), 32'd5);
    drain();
`else
    // without detection a jal-to-self loop keeps being captured
    do_reset();
    for (int i = 0; i < 10; i++) retire(32'h80, JAL, 1);
    chk("t6_halted", 32'(halted_o), 32'd0);
    chk("t6_count", 32'(count_o), 32'd10);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
